// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the AES block UART receiver and its matching
// block transmitter.
//   rx_state_t           - byte-level receive FSM states
//   BYTES_PER_BLOCK      - bytes per AES block on the wire
//   BLOCK_BITS           - width of one assembled block
//   DEFAULT_CLKS_PER_BIT - 100 MHz system clock / 9600 baud
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int BYTES_PER_BLOCK      = 16;
    localparam int BLOCK_BITS           = 8 * BYTES_PER_BLOCK;
    localparam int DEFAULT_CLKS_PER_BIT = 10417;

endpackage

// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
// Receives one 8N1 character (8 data bits LSB first, >= 1 stop bit) from an
// asynchronous serial line.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high
//   rx         in   asynchronous serial line, idles high
//   byte_data  out  last character shifted in (valid while byte_ok is high)
//   byte_ok    out  one-cycle strobe in the stop-sample cycle, stop bit high
//   byte_err   out  one-cycle strobe in the stop-sample cycle, stop bit low
//   busy       out  high whenever the FSM is not in IDLE
// byte_ok/byte_err are combinational so the parent can register its own
// pulses exactly one cycle after the stop sample.
// -----------------------------------------------------------------------------
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_ok,
    output logic       byte_err,
    output logic       busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);

    // Two-flop synchronizer; flops reset to the idle (high) line level so a
    // reset never looks like a falling edge.
    logic rx_meta_reg;
    logic rx_s_reg;

    rx_state_t        state_reg,   state_next;
    logic [CNT_W-1:0] clk_cnt_reg, clk_cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg,   shift_next;

    logic half_done;
    logic bit_done;

    assign half_done = (clk_cnt_reg == CNT_W'(HALF_BIT - 1));
    assign bit_done  = (clk_cnt_reg == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
            state_reg   <= IDLE;
            clk_cnt_reg <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
            state_reg   <= state_next;
            clk_cnt_reg <= clk_cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clk_cnt_next = clk_cnt_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        byte_ok      = 1'b0;
        byte_err     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!rx_s_reg) begin
                    state_next   = START;
                    clk_cnt_next = '0;
                end
            end

            // Half a bit in: a start bit that is already high again was a
            // glitch, otherwise every later sample lands mid-bit.
            START: begin
                if (half_done) begin
                    clk_cnt_next = '0;
                    if (rx_s_reg) begin
                        state_next = IDLE;
                    end else begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + CNT_W'(1);
                end
            end

            DATA: begin
                if (bit_done) begin
                    clk_cnt_next            = '0;
                    shift_next[bit_idx_reg] = rx_s_reg;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + CNT_W'(1);
                end
            end

            // Back to IDLE straight after the stop sample, so any further
            // stop bits are just idle line.
            STOP: begin
                if (bit_done) begin
                    clk_cnt_next = '0;
                    state_next   = IDLE;
                    if (rx_s_reg) begin
                        byte_ok = 1'b1;
                    end else begin
                        byte_err = 1'b1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + CNT_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign byte_data = shift_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: rtl/uart_rx_block.sv
// -----------------------------------------------------------------------------
// uart_rx_block
// Rebuilds 128-bit AES blocks from a UART byte stream; the first byte
// received lands in data[127:120], the sixteenth in data[7:0].
// Ports:
//   clk         in   system clock
//   reset       in   synchronous, active-high
//   rx          in   asynchronous serial line, idles high
//   data        out  last complete block, held until the next one completes
//   data_valid  out  one-cycle pulse, data is new this cycle
//   frame_err   out  one-cycle pulse, a stop bit was sampled low
//   busy        out  high while a character is in flight
// A framing error or an idle gap of IDLE_TIMEOUT_BITS bit-times in the middle
// of a block discards the partial block; neither ever touches data.
// -----------------------------------------------------------------------------
module uart_rx_block
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT      = DEFAULT_CLKS_PER_BIT,
    parameter int IDLE_TIMEOUT_BITS = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx,
    output logic [127:0] data,
    output logic         data_valid,
    output logic         frame_err,
    output logic         busy
);

    localparam int TIMEOUT_CYCLES = IDLE_TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int IDLE_W         = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BCNT_W         = $clog2(BYTES_PER_BLOCK);
    // The last byte goes straight from the byte receiver into data, so only
    // the leading BYTES_PER_BLOCK-1 bytes need assembly storage.
    localparam int ASM_BITS       = BLOCK_BITS - 8;

    logic [7:0] byte_data;
    logic       byte_ok;
    logic       byte_err;
    logic       rx_busy;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_byte (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .byte_data(byte_data),
        .byte_ok  (byte_ok),
        .byte_err (byte_err),
        .busy     (rx_busy)
    );

    logic [BCNT_W-1:0]  byte_cnt_reg;
    logic [IDLE_W-1:0]  idle_cnt_reg;
    logic [ASM_BITS-1:0] assembly_w;
    logic [127:0]       data_reg;
    logic               data_valid_reg;
    logic               frame_err_reg;
    logic               timeout_w;

    // Idle time is only measured between characters of a partial block.
    assign timeout_w = !rx_busy && (byte_cnt_reg != '0) &&
                       (idle_cnt_reg == IDLE_W'(TIMEOUT_CYCLES - 1));

    // One slot register per leading byte position, byte 0 at the MSB end.
    for (genvar gi = 0; gi < BYTES_PER_BLOCK - 1; gi++) begin : g_slot
        localparam int SLOT_MSB = ASM_BITS - 1 - 8 * gi;
        logic [7:0] slot_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                slot_reg <= '0;
            end else if (byte_ok && (byte_cnt_reg == BCNT_W'(gi))) begin
                slot_reg <= byte_data;
            end
        end

        assign assembly_w[SLOT_MSB -: 8] = slot_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_reg   <= '0;
            idle_cnt_reg   <= '0;
            data_reg       <= '0;
            data_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            data_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;

            if (byte_ok) begin
                if (byte_cnt_reg == BCNT_W'(BYTES_PER_BLOCK - 1)) begin
                    data_reg       <= {assembly_w, byte_data};
                    data_valid_reg <= 1'b1;
                    byte_cnt_reg   <= '0;
                end else begin
                    byte_cnt_reg <= byte_cnt_reg + BCNT_W'(1);
                end
            end else if (byte_err) begin
                frame_err_reg <= 1'b1;
                byte_cnt_reg  <= '0;
            end else if (timeout_w) begin
                byte_cnt_reg <= '0;
            end

            if (rx_busy || (byte_cnt_reg == '0) || timeout_w) begin
                idle_cnt_reg <= '0;
            end else begin
                idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
            end
        end
    end

    assign data       = data_reg;
    assign data_valid = data_valid_reg;
    assign frame_err  = frame_err_reg;
    assign busy       = rx_busy;

endmodule

// File: tb/tb_uart_rx_block.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_block
// Drives serial characters into uart_rx_block and compares the delivered
// blocks and pulses against a byte-queue model of the block receiver.
// -----------------------------------------------------------------------------
module tb_uart_rx_block;

    localparam int CPB      = 16;
    localparam int TO_BITS  = 64;
    localparam int TIMEOUT  = TO_BITS * CPB;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         rx    = 1'b1;
    logic [127:0] data;
    logic         data_valid;
    logic         frame_err;
    logic         busy;

    always #5 clk = ~clk;

    uart_rx_block #(
        .CLKS_PER_BIT     (CPB),
        .IDLE_TIMEOUT_BITS(TO_BITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data      (data),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    int errors = 0;
    int checks = 0;

    // Observed side
    int           dv_seen     = 0;
    int           fe_seen     = 0;
    int           data_glitch = 0;
    logic [127:0] got_q[$];
    logic [127:0] prev_data   = '0;
    logic         reset_d     = 1'b1;

    // Model side
    logic [7:0]   part_q[$];
    logic [127:0] exp_q[$];
    logic [127:0] exp_last = '0;
    int           exp_dv   = 0;
    int           exp_fe   = 0;

    always @(posedge clk) reset_d <= reset;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_seen++;
            got_q.push_back(data);
        end
        if (frame_err) fe_seen++;
        if (!reset_d && !data_valid && (data !== prev_data)) data_glitch++;
        prev_data = data;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Model: good bytes accumulate; 16 of them form a block (first byte most
    // significant); a bad stop bit drops the partial block.
    task automatic model_byte(input logic [7:0] b, input logic stop_ok);
        logic [127:0] blk;
        if (!stop_ok) begin
            part_q.delete();
            exp_fe++;
        end else begin
            part_q.push_back(b);
            if (part_q.size() == 16) begin
                blk = '0;
                for (int i = 0; i < 16; i++) blk = {blk[119:0], part_q[i]};
                exp_q.push_back(blk);
                exp_last = blk;
                exp_dv++;
                part_q.delete();
            end
        end
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int nstop);
        model_byte(b, stop_ok);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_ok);
        for (int i = 1; i < nstop; i++) send_bit(1'b1);
    endtask

    task automatic idle_line(input int cycles);
        rx = 1'b1;
        repeat (cycles) @(negedge clk);
        if (cycles >= TIMEOUT) part_q.delete();
    endtask

    task automatic send_random_block(input int nstop);
        for (int i = 0; i < 16; i++) send_byte(8'($urandom_range(0, 255)), 1'b1, nstop);
    endtask

    task automatic verify(input string tag);
        logic [127:0] g;
        logic [127:0] e;
        idle_line(3 * CPB);
        check({tag, "_dv_count"}, 128'(dv_seen), 128'(exp_dv));
        check({tag, "_fe_count"}, 128'(fe_seen), 128'(exp_fe));
        check({tag, "_data"}, data, exp_last);
        check({tag, "_busy_idle"}, 128'(busy), 128'(0));
        check({tag, "_data_glitch"}, 128'(data_glitch), 128'(0));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_block"}, g, e);
        end
        got_q.delete();
        exp_q.delete();
        $display("step %s: dv=%0d fe=%0d data=%h", tag, dv_seen, fe_seen, data);
    endtask

    initial begin
        logic [7:0] b;

        // Reset state
        rx    = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", data, 128'(0));
        check("rst_data_valid", 128'(data_valid), 128'(0));
        check("rst_frame_err", 128'(frame_err), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Incrementing block, 2 stop bits
        for (int i = 0; i < 16; i++) send_byte(8'(i * 17), 1'b1, 2);
        verify("incr_block");
        check("incr_block_const", data, 128'h00112233445566778899AABBCCDDEEFF);

        // Start-bit glitch shorter than half a bit
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_busy", 128'(busy), 128'(0));
        verify("glitch_only");
        send_random_block(2);
        verify("after_glitch");

        // Framing error on byte 6
        for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), 1'b1, 2);
        send_byte(8'($urandom_range(0, 255)), 1'b0, 2);
        verify("frame_err");
        send_random_block(2);
        verify("after_frame_err");

        // Idle timeout discards a 7-byte partial block
        for (int i = 0; i < 7; i++) send_byte(8'($urandom_range(0, 255)), 1'b1, 2);
        idle_line(TIMEOUT);
        for (int i = 0; i < 16; i++) send_byte(8'hA5, 1'b1, 2);
        verify("timeout");
        check("timeout_const", data, {16{8'hA5}});

        // Gap shorter than the timeout keeps the partial block
        for (int i = 0; i < 7; i++) send_byte(8'($urandom_range(0, 255)), 1'b1, 2);
        idle_line(TIMEOUT - 8 * CPB);
        for (int i = 0; i < 9; i++) send_byte(8'($urandom_range(0, 255)), 1'b1, 2);
        verify("short_gap");

        // Reset during bit 3 of byte 10
        for (int i = 0; i < 9; i++) send_byte(8'($urandom_range(0, 255)), 1'b1, 2);
        b = 8'($urandom_range(0, 255));
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(b[i]);
        rx = b[3];
        repeat (8) @(negedge clk);
        check("mid_byte_busy", 128'(busy), 128'(1));
        reset = 1'b1;
        rx    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_data", data, 128'(0));
        check("mid_rst_data_valid", 128'(data_valid), 128'(0));
        check("mid_rst_frame_err", 128'(frame_err), 128'(0));
        check("mid_rst_busy", 128'(busy), 128'(0));
        part_q.delete();
        exp_last = '0;
        idle_line(20 * CPB);
        send_random_block(2);
        verify("after_reset");

        // Two blocks back-to-back, single stop bit
        send_random_block(1);
        send_random_block(1);
        verify("back_to_back");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
